membrane_buffer_bank: RTL and testbench

- Double-buffered (ping-pong) store of final-hidden-layer membrane potentials, one NUM_NEURONS-wide vector per timestep.
- Sits between the output LIF layer, which writes one vector per timestep, and the Q-value accumulator, which reads all neurons at a shared timestep index.
- Fills one bank while the accumulator reads the other, so inference N+1 simulation overlaps Q computation of inference N.
- Issues the accumulator's start pulse and frees a bank on the accumulator's done.

---
 rtl/membrane_buffer_bank.sv | 156 +++++++++++++++
 tb/tb_membrane_buffer_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/membrane_buffer_bank.sv
// Ping-pong membrane-potential store between the output LIF layer and the Q-value accumulator.
// Optional stall counter output enabled by defining MEMBUF_STALL_CNT_EN.
module membrane_buffer_bank #(
    parameter int unsigned NUM_NEURONS    = 16,
    parameter int unsigned NUM_TIMESTEPS  = 30,
    parameter int unsigned MEMBRANE_WIDTH = 24
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          flush,
    input  logic                                          wr_valid,
    output logic                                          wr_ready,
    input  logic [NUM_NEURONS-1:0][MEMBRANE_WIDTH-1:0]    wr_membrane,
    input  logic [$clog2(NUM_TIMESTEPS)-1:0]              read_timestep,
    output logic [NUM_NEURONS-1:0][MEMBRANE_WIDTH-1:0]    membrane_out,
    output logic                                          acc_start,
    input  logic                                          acc_done,
    output logic [1:0]                                    banks_full
`ifdef MEMBUF_STALL_CNT_EN
    ,
    output logic [15:0]                                   stall_cycles
`endif
);

    localparam int unsigned TS_W = $clog2(NUM_TIMESTEPS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    logic [NUM_NEURONS-1:0][MEMBRANE_WIDTH-1:0] mem [2][NUM_TIMESTEPS];

    logic [1:0]      state_q, state_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [TS_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]      full_q, full_d;
    logic            reading_q, reading_d;
    logic            acc_start_q, acc_start_d;
    logic            wr_fire_c;
    logic            release_c;
    logic            rd_valid_c;
    logic [TS_W-1:0] rd_idx_c;

    // Write side: accept, advance pointer, close the bank on its last timestep
    always_comb begin
        wr_ready  = !full_q[wr_bank_q];
        wr_fire_c = wr_valid && wr_ready && !flush;
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        if (flush) begin
            wr_ptr_d = '0;
        end else if (wr_fire_c) begin
            if (wr_ptr_q == TS_W'(NUM_TIMESTEPS - 1)) begin
                wr_ptr_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + TS_W'(1);
            end
        end
        // A released bank is never the one being closed: it was full, the write bank was not
        if (release_c) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Read-side FSM: start the accumulator once per full bank, release on done
    always_comb begin
        state_d   = state_q;
        reading_d = reading_q;
        rd_bank_d = rd_bank_q;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q] && !reading_q) begin
                    state_d   = ARMED;
                    reading_d = 1'b1;
                end
            end
            ARMED: state_d = BUSY;
            BUSY: begin
                if (acc_done) begin
                    state_d   = IDLE;
                    reading_d = 1'b0;
                    release_c = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                end
            end
            default: state_d = IDLE;
        endcase
        acc_start_d = (state_d == ARMED);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            full_q      <= 2'b00;
            reading_q   <= 1'b0;
            acc_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            reading_q   <= reading_d;
            acc_start_q <= acc_start_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_fire_c) begin
            mem[wr_bank_q][wr_ptr_q] <= wr_membrane;
        end
    end

    // Asynchronous read, zeroed for an empty bank or an out-of-range index
    always_comb begin
        rd_valid_c   = full_q[rd_bank_q] && (32'(read_timestep) < NUM_TIMESTEPS);
        rd_idx_c     = rd_valid_c ? read_timestep : '0;
        membrane_out = '0;
        if (rd_valid_c) begin
            membrane_out = mem[rd_bank_q][rd_idx_c];
        end
    end

    assign acc_start  = acc_start_q;
    assign banks_full = full_q;

`ifdef MEMBUF_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_membrane_buffer_bank.sv
// Directed self-checking bench for membrane_buffer_bank (stall counter checked when MEMBUF_STALL_CNT_EN is defined).
module tb_membrane_buffer_bank;

    localparam int unsigned NN   = 16;
    localparam int unsigned NT   = 30;
    localparam int unsigned MW   = 24;
    localparam int unsigned TS_W = $clog2(NT);

    logic                      clk;
    logic                      reset_n;
    logic                      flush;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [NN-1:0][MW-1:0]     wr_membrane;
    logic [TS_W-1:0]           read_timestep;
    logic [NN-1:0][MW-1:0]     membrane_out;
    logic                      acc_start;
    logic                      acc_done;
    logic [1:0]                banks_full;
`ifdef MEMBUF_STALL_CNT_EN
    logic [15:0]               stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    membrane_buffer_bank #(
        .NUM_NEURONS(NN), .NUM_TIMESTEPS(NT), .MEMBRANE_WIDTH(MW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_membrane(wr_membrane),
        .read_timestep(read_timestep), .membrane_out(membrane_out),
        .acc_start(acc_start), .acc_done(acc_done), .banks_full(banks_full)
`ifdef MEMBUF_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern: tag selects the data set, t the timestep, n the neuron
    function automatic logic [MW-1:0] pat(input int tag, input int t, input int n);
        return MW'(tag * 65536 + t * 256 + n);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input int tag, input int t);
        wr_valid = 1'b1;
        for (int n = 0; n < NN; n++) wr_membrane[n] = pat(tag, t, n);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_done();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; acc_done = 1'b0;
        wr_membrane = '0; read_timestep = '0;
        tick();
        reset_n = 1'b1;
        check("rst_full", 64'(banks_full), 64'd0);
        check("rst_ready", 64'(wr_ready), 64'd1);
        check("rst_start", 64'(acc_start), 64'd0);
        check("rst_out_zero", 64'(membrane_out == '0), 64'd1);

        // Fill bank0
        for (int t = 0; t < NT; t++) write_vec(0, t);
        check("fill0_full", 64'(banks_full), 64'd1);
        check("fill0_start_early", 64'(acc_start), 64'd0);
        tick();
        check("fill0_start", 64'(acc_start), 64'd1);
        read_timestep = TS_W'(5);
        #1;
        check("fill0_rd5_n3", 64'(membrane_out[3]), 64'd1283);
        read_timestep = TS_W'(31);
        #1;
        check("rd_out_of_range", 64'(membrane_out == '0), 64'd1);
        tick();
        check("fill0_start_pulse", 64'(acc_start), 64'd0);

        // Fill bank1 while bank0 is being read, then stall
        for (int t = 0; t < NT; t++) write_vec(1, t);
        check("both_full", 64'(banks_full), 64'd3);
        check("both_ready", 64'(wr_ready), 64'd0);
        wr_valid = 1'b1;
        for (int n = 0; n < NN; n++) wr_membrane[n] = pat(2, 0, n);
        for (int i = 0; i < 10; i++) tick();
        wr_valid = 1'b0;
        check("stall_ready", 64'(wr_ready), 64'd0);
        read_timestep = TS_W'(7);
        #1;
        check("stall_rd7_n2", 64'(membrane_out[2]), 64'(pat(0, 7, 2)));
`ifdef MEMBUF_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'd10);
`endif

        // Release bank0, bank1 gets started next
        pulse_done();
        check("rel_full", 64'(banks_full), 64'd2);
        check("rel_ready", 64'(wr_ready), 64'd1);
        check("rel_start_early", 64'(acc_start), 64'd0);
        tick();
        check("rel_start", 64'(acc_start), 64'd1);
        read_timestep = TS_W'(0);
        #1;
        check("bank1_rd0_n0", 64'(membrane_out[0]), 64'(pat(1, 0, 0)));
        tick();
        pulse_done();
        check("rel1_full", 64'(banks_full), 64'd0);

        // Partial fill then flush (with a write presented on the flush cycle)
        for (int t = 0; t < 12; t++) write_vec(2, t);
        flush = 1'b1;
        write_vec(2, 12);
        flush = 1'b0;
        for (int t = 0; t < NT - 1; t++) write_vec(3, t);
        check("flush_29_full", 64'(banks_full), 64'd0);
        check("flush_29_start", 64'(acc_start), 64'd0);
        write_vec(3, NT - 1);
        check("flush_30_full", 64'(banks_full), 64'd1);
        tick();
        check("flush_start", 64'(acc_start), 64'd1);
        read_timestep = TS_W'(11);
        #1;
        check("flush_rd11_n5", 64'(membrane_out[5]), 64'(pat(3, 11, 5)));
        read_timestep = TS_W'(0);
        #1;
        check("flush_rd0_n0", 64'(membrane_out[0]), 64'(pat(3, 0, 0)));
        tick();

        // Mid-BUSY and mid-fill reset
        for (int t = 0; t < 15; t++) write_vec(1, t);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mrst_full", 64'(banks_full), 64'd0);
        check("mrst_ready", 64'(wr_ready), 64'd1);
        check("mrst_start", 64'(acc_start), 64'd0);
        check("mrst_out_zero", 64'(membrane_out == '0), 64'd1);
`ifdef MEMBUF_STALL_CNT_EN
        check("mrst_stall", 64'(stall_cycles), 64'd0);
`endif
        pulse_done();
        check("mrst_done_full", 64'(banks_full), 64'd0);
        tick();
        check("mrst_done_start", 64'(acc_start), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
